// File: rtl/riscv_mem_stage.sv
// RV32I MEM stage: drives the data-memory port from EX/MEM values, aligns loads/stores, holds the MEM/WB register.
// Optional MEM_MISALIGN_CHECK_EN: suppresses misaligned half/word accesses instead of truncating the address.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`define MEM_READ 0
`define MEM_WRITE 1
`define MEM_UNSIGNED 2
`define MEM_WIDTH 4:3
`define MEM_BYTE 2'b00
`define MEM_HALF 2'b01
`define MEM_WORD 2'b10
`endif

module riscv_mem_stage (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [31:0]                       ex_pc,
  input  logic [31:0]                       ex_alu_result,
  input  logic [31:0]                       ex_rs2_data,
  input  logic [4:0]                        ex_rd_addr,
  input  logic [`CONTROL_SIGNALS_WIDTH-1:0] ex_control_signals,
  input  logic                              ex_valid,
  output logic [31:0]                       dmem_addr,
  input  logic [31:0]                       dmem_data_in,
  output logic [31:0]                       dmem_data_out,
  output logic                              dmem_read,
  output logic                              dmem_write,
  output logic [3:0]                        dmem_byte_enable,
  output logic [31:0]                       wb_pc,
  output logic [31:0]                       wb_alu_result,
  output logic [31:0]                       wb_mem_data,
  output logic [4:0]                        wb_rd_addr,
  output logic [`CONTROL_SIGNALS_WIDTH-1:0] wb_control_signals,
  output logic                              wb_valid
);

  logic [1:0]  offset;
  logic [1:0]  width;
  logic        is_unsigned;
  logic        misaligned;
  logic [3:0]  lane_en;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign offset      = ex_alu_result[1:0];
  assign width       = ex_control_signals[`MEM_WIDTH];
  assign is_unsigned = ex_control_signals[`MEM_UNSIGNED];

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (width == `MEM_HALF)
      misaligned = offset[0];
    else if (width != `MEM_BYTE)
      misaligned = (offset != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  assign dmem_addr  = ex_alu_result;
  assign dmem_read  = ex_valid & ~misaligned & ex_control_signals[`MEM_READ];
  assign dmem_write = ex_valid & ~misaligned & ex_control_signals[`MEM_WRITE];

  // Big-endian lane order: offset 0 lives in bits 31:24, enable bit 3.
  always_comb begin
    load_byte = dmem_data_in[31:24];
    case (offset)
      2'd0: load_byte = dmem_data_in[31:24];
      2'd1: load_byte = dmem_data_in[23:16];
      2'd2: load_byte = dmem_data_in[15:8];
      2'd3: load_byte = dmem_data_in[7:0];
      default: load_byte = dmem_data_in[31:24];
    endcase
    load_half = offset[1] ? dmem_data_in[15:0] : dmem_data_in[31:16];
  end

  always_comb begin
    lane_en    = 4'b1111;
    store_data = ex_rs2_data;
    load_data  = dmem_data_in;
    case (width)
      `MEM_BYTE: begin
        lane_en    = 4'b1000 >> offset;
        store_data = {ex_rs2_data[7:0], 24'h0} >> {offset, 3'b000};
        load_data  = {{24{~is_unsigned & load_byte[7]}}, load_byte};
      end
      `MEM_HALF: begin
        lane_en    = offset[1] ? 4'b0011 : 4'b1100;
        store_data = offset[1] ? {16'h0, ex_rs2_data[15:0]} : {ex_rs2_data[15:0], 16'h0};
        load_data  = {{16{~is_unsigned & load_half[15]}}, load_half};
      end
      default: begin
        lane_en    = 4'b1111;
        store_data = ex_rs2_data;
        load_data  = dmem_data_in;
      end
    endcase
  end

  assign dmem_byte_enable = (dmem_read | dmem_write) ? lane_en : 4'b0000;
  assign dmem_data_out    = store_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_pc              <= 32'h0;
      wb_alu_result      <= 32'h0;
      wb_mem_data        <= 32'h0;
      wb_rd_addr         <= 5'h0;
      wb_control_signals <= '0;
      wb_valid           <= 1'b0;
    end else begin
      wb_pc              <= ex_pc;
      wb_alu_result      <= ex_alu_result;
      wb_mem_data        <= dmem_read ? load_data : 32'h0;
      wb_rd_addr         <= ex_rd_addr;
      wb_control_signals <= ex_control_signals;
      wb_valid           <= ex_valid;
    end
  end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Randomized self-checking bench for riscv_mem_stage against a spec-level reference model.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`define MEM_READ 0
`define MEM_WRITE 1
`define MEM_UNSIGNED 2
`define MEM_WIDTH 4:3
`define MEM_BYTE 2'b00
`define MEM_HALF 2'b01
`define MEM_WORD 2'b10
`endif

module tb_riscv_mem_stage;
  localparam int CW = `CONTROL_SIGNALS_WIDTH;
  localparam int EW = 32 + 32 + 32 + 5 + CW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   ex_pc, ex_alu_result, ex_rs2_data, dmem_data_in;
  logic [4:0]    ex_rd_addr;
  logic [CW-1:0] ex_control_signals;
  logic          ex_valid;
  logic [31:0]   dmem_addr, dmem_data_out;
  logic          dmem_read, dmem_write;
  logic [3:0]    dmem_byte_enable;
  logic [31:0]   wb_pc, wb_alu_result, wb_mem_data;
  logic [4:0]    wb_rd_addr;
  logic [CW-1:0] wb_control_signals;
  logic          wb_valid;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  riscv_mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_control_signals(ex_control_signals), .ex_valid(ex_valid),
    .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_rd_addr(wb_rd_addr), .wb_control_signals(wb_control_signals), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_ctrl(input bit ld, input bit st, input bit uns,
                                            input logic [1:0] w, input logic [CW-1:0] extra);
    logic [CW-1:0] c;
    c = extra;
    c[`MEM_READ]     = ld;
    c[`MEM_WRITE]    = st;
    c[`MEM_UNSIGNED] = uns;
    c[`MEM_WIDTH]    = w;
    return c;
  endfunction

  // Reference: byte k of a word is bits [31-8k -: 8]; halves at k=0 and k=2.
  task automatic apply(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [CW-1:0] ctrl, input bit valid,
                       input logic [31:0] din);
    int k, sh;
    bit ld, st, uns, mis, r, w;
    logic [1:0]  wd;
    logic [3:0]  be;
    logic [31:0] sdata, ldata;
    logic [EW-1:0] e;
    @(negedge clk);
    ex_pc = pc; ex_alu_result = addr; ex_rs2_data = rs2; ex_rd_addr = rd;
    ex_control_signals = ctrl; ex_valid = valid; dmem_data_in = din;
    #1;
    k   = int'(addr[1:0]);
    ld  = ctrl[`MEM_READ];
    st  = ctrl[`MEM_WRITE];
    uns = ctrl[`MEM_UNSIGNED];
    wd  = ctrl[`MEM_WIDTH];
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    if (wd == `MEM_HALF) mis = (k % 2) != 0;
    else if (wd == `MEM_WORD) mis = (k != 0);
`endif
    r = valid && ld && !mis;
    w = valid && st && !mis;
    if (wd == `MEM_BYTE) begin
      sh    = 8 * (3 - k);
      be    = 4'(1 << (3 - k));
      sdata = (rs2 & 32'hFF) << sh;
      ldata = (din >> sh) & 32'hFF;
      if (!uns && ldata[7]) ldata = ldata | 32'hFFFFFF00;
    end else if (wd == `MEM_HALF) begin
      sh    = (k >= 2) ? 0 : 16;
      be    = (k >= 2) ? 4'b0011 : 4'b1100;
      sdata = (rs2 & 32'hFFFF) << sh;
      ldata = (din >> sh) & 32'hFFFF;
      if (!uns && ldata[15]) ldata = ldata | 32'hFFFF0000;
    end else begin
      be    = 4'b1111;
      sdata = rs2;
      ldata = din;
    end
    if (!(r || w)) be = 4'b0000;
    if (!r) ldata = 32'h0;
    check("dmem_addr", dmem_addr, addr);
    check("dmem_read", 32'(dmem_read), 32'(r));
    check("dmem_write", 32'(dmem_write), 32'(w));
    check("byte_enable", 32'(dmem_byte_enable), 32'(be));
    if (w) check("data_out", dmem_data_out, sdata);
    exp_q.push_back({pc, addr, ldata, rd, ctrl, valid});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("wb_valid", 32'(wb_valid), 32'(e[0]));
    if (e[0]) begin
      check("wb_pc", wb_pc, e[EW-1 -: 32]);
      check("wb_alu_result", wb_alu_result, e[EW-33 -: 32]);
      check("wb_mem_data", wb_mem_data, e[EW-65 -: 32]);
      check("wb_rd_addr", 32'(wb_rd_addr), 32'(e[CW+5 -: 5]));
      check("wb_control", 32'(wb_control_signals), 32'(e[CW:1]));
    end
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_pc"}, wb_pc, 32'h0);
    check({tag, "_alu"}, wb_alu_result, 32'h0);
    check({tag, "_mem"}, wb_mem_data, 32'h0);
    check({tag, "_rd"}, 32'(wb_rd_addr), 32'h0);
    check({tag, "_ctrl"}, 32'(wb_control_signals), 32'h0);
    check({tag, "_valid"}, 32'(wb_valid), 32'h0);
  endtask

  initial begin
    logic [1:0] wsel;
    int op;
    reset = 1'b1;
    ex_pc = 32'h1234; ex_alu_result = 32'h0; ex_rs2_data = 32'h0; ex_rd_addr = 5'd7;
    ex_control_signals = mk_ctrl(1, 0, 0, `MEM_WORD, '0); ex_valid = 1'b1;
    dmem_data_in = 32'h5555AAAA;
    @(posedge clk); #1;
    check_wb_zero("reset");
    // strobes stay combinational during reset
    check("reset_read_comb", 32'(dmem_read), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    apply(32'h100, 32'h0, 32'h0, 5'd1, mk_ctrl(1, 0, 1, `MEM_BYTE, '0), 1, 32'hFF000000);
    check("lbu_lit", wb_mem_data, 32'h000000FF);
    check("lbu_read_lit", 32'(dmem_read), 32'h1);
    apply(32'h104, 32'h0, 32'h0, 5'd2, mk_ctrl(1, 0, 0, `MEM_BYTE, '0), 1, 32'h80000000);
    check("lb_lit", wb_mem_data, 32'hFFFFFF80);
    apply(32'h108, 32'h2, 32'h0, 5'd3, mk_ctrl(1, 0, 1, `MEM_HALF, '0), 1, 32'h0000FFFF);
    check("lhu_lit", wb_mem_data, 32'h0000FFFF);
    apply(32'h10C, 32'h2, 32'h0, 5'd4, mk_ctrl(1, 0, 0, `MEM_HALF, '0), 1, 32'h00008000);
    check("lh_lit", wb_mem_data, 32'hFFFF8000);
    apply(32'h110, 32'h40, 32'h0, 5'd5, mk_ctrl(1, 0, 0, `MEM_WORD, '0), 1, 32'hCAFEBABE);
    check("lw_lit", wb_mem_data, 32'hCAFEBABE);
    check("lw_pc_lit", wb_pc, 32'h110);
    check("lw_rd_lit", 32'(wb_rd_addr), 32'd5);
    apply(32'h114, 32'h1, 32'hDEADBEEF, 5'd0, mk_ctrl(0, 1, 0, `MEM_BYTE, '0), 1, 32'h0);
    check("sb_be_lit", 32'(dmem_byte_enable), 32'h4);
    check("sb_data_lit", 32'(dmem_data_out[23:16]), 32'hEF);
    apply(32'h118, 32'h2, 32'hDEADBEEF, 5'd0, mk_ctrl(0, 1, 0, `MEM_HALF, '0), 1, 32'h0);
    check("sh_be_lit", 32'(dmem_byte_enable), 32'h3);
    check("sh_data_lit", 32'(dmem_data_out[15:0]), 32'hBEEF);
    apply(32'h11C, 32'h8, 32'hDEADBEEF, 5'd0, mk_ctrl(0, 1, 0, `MEM_WORD, '0), 1, 32'h0);
    check("sw_be_lit", 32'(dmem_byte_enable), 32'hF);
    apply(32'h120, 32'h8, 32'hDEADBEEF, 5'd0, mk_ctrl(0, 1, 0, `MEM_WORD, '0), 0, 32'h0);
    check("inv_write_lit", 32'(dmem_write), 32'h0);
    check("inv_valid_lit", 32'(wb_valid), 32'h0);

    for (int i = 0; i < 400; i++) begin
      op   = $urandom_range(0, 2);
      wsel = 2'($urandom_range(0, 2));
      apply($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
            mk_ctrl(op == 0, op == 1, 1'($urandom_range(0, 1)), wsel, CW'($urandom)),
            $urandom_range(0, 7) != 0, $urandom);
    end

    // reset mid-stream has priority over the load
    @(negedge clk);
    ex_pc = 32'hABCD; ex_control_signals = mk_ctrl(1, 0, 0, `MEM_WORD, '0);
    ex_alu_result = 32'h0; ex_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    check_wb_zero("reset2");
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
